// File: rtl/parallel_to_serial.sv
// parallel_to_serial
//   Transmit side of the 1-bit serial link. A width-bit word is accepted over a
//   valid/ready handshake and sent one bit per transfer, LSB first. serial_last
//   marks the final bit of each word, so a serial_to_parallel receiver can
//   reassemble the word directly.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   parallel_valid  upstream word present
//   parallel_data   upstream word (width bits)
//   parallel_ready  block can accept a word this cycle
//   serial_ready    downstream accepts the current bit
//   serial_valid    serial_data holds a valid bit
//   serial_data     current bit (LSB first)
//   serial_last     high with the bit at index width-1
//
// Optional feature
//   P2S_PRELOAD_EN  adds a one-word holding register so that consecutive
//                   words stream without an idle cycle between them.
//                   Undefined (default): one idle cycle separates words.

module parallel_to_serial #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  input  logic [width-1:0] parallel_data,
  output logic             parallel_ready,
  input  logic             serial_ready,
  output logic             serial_valid,
  output logic             serial_data,
  output logic             serial_last
);

  localparam int cnt_w = $clog2(width);
  localparam logic [cnt_w-1:0] last_idx = cnt_w'(width - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_next;
  logic [width-1:0] shift_reg, shift_next;
  logic [cnt_w-1:0] counter, counter_next;
  logic             accept;
  logic             transfer;
  logic             last_transfer;

`ifdef P2S_PRELOAD_EN
  logic [width-1:0] hold_reg, hold_next;
  logic             hold_full, hold_full_next;
`endif

  // All outputs depend on registered state only.
  assign serial_valid  = (state == SHIFT);
  assign serial_data   = shift_reg[0];
  assign serial_last   = serial_valid & (counter == last_idx);

`ifdef P2S_PRELOAD_EN
  assign parallel_ready = !hold_full;
`else
  assign parallel_ready = (state == IDLE);
`endif

  assign accept        = parallel_valid & parallel_ready;
  assign transfer      = serial_valid & serial_ready;
  assign last_transfer = transfer & (counter == last_idx);

  // Next-state logic. The shift register is cleared when the link goes idle so
  // serial_data rests at 0 between words.
  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    counter_next = counter;
`ifdef P2S_PRELOAD_EN
    hold_next      = hold_reg;
    hold_full_next = hold_full;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_next   = SHIFT;
          shift_next   = parallel_data;
          counter_next = '0;
        end
      end
      SHIFT: begin
        if (transfer) begin
          if (counter == last_idx) begin
            state_next   = IDLE;
            shift_next   = '0;
            counter_next = '0;
`ifdef P2S_PRELOAD_EN
            // Chain the next word on the same edge: the held word first,
            // otherwise a word arriving right now bypasses the holding register.
            if (hold_full) begin
              state_next     = SHIFT;
              shift_next     = hold_reg;
              hold_full_next = 1'b0;
            end else if (accept) begin
              state_next = SHIFT;
              shift_next = parallel_data;
            end
`endif
          end else begin
            shift_next   = shift_reg >> 1;
            counter_next = counter + cnt_w'(1);
          end
        end
`ifdef P2S_PRELOAD_EN
        // A word accepted mid-word waits in the holding register, unless it
        // was already loaded straight into the shift register above.
        if (accept && !(last_transfer && !hold_full)) begin
          hold_next      = parallel_data;
          hold_full_next = 1'b1;
        end
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset discards any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      counter   <= '0;
`ifdef P2S_PRELOAD_EN
      hold_reg  <= '0;
      hold_full <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      counter   <= counter_next;
`ifdef P2S_PRELOAD_EN
      hold_reg  <= hold_next;
      hold_full <= hold_full_next;
`endif
    end
  end

endmodule
